// File: rtl/bkt_lvl_finder_pkg.sv
// rtl/bkt_lvl_finder_pkg.sv - shared SAT engine types for the backtrack-level finder
// Width defaults, FSM state encoding and chain findflag encoding.
package bkt_lvl_finder_pkg;

  localparam int WIDTH_LVL_DEF    = 16;
  localparam int WIDTH_BIN_ID_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_APPLY   = 3'd3,
    ST_DONE    = 3'd4
  } bkt_state_e;

  localparam logic [1:0] FLAG_NONE     = 2'd0;
  localparam logic [1:0] FLAG_HERE     = 2'd1;
  localparam logic [1:0] FLAG_UPSTREAM = 2'd2;

endpackage

// File: rtl/bkt_lvl_finder.sv
// rtl/bkt_lvl_finder.sv - find-backtrack-level / apply-backtrack initiator
// Drives the search level into the cell chain, captures the result, pulses apply, hands back.
module bkt_lvl_finder
  import bkt_lvl_finder_pkg::*;
#(
  parameter int WIDTH_LVL     = WIDTH_LVL_DEF,
  parameter int WIDTH_BIN_ID  = WIDTH_BIN_ID_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_LVL-1:0]    max_lvl_i,
  input  logic                    abort_i,
  output logic [WIDTH_LVL-1:0]    max_lvl_o,
  output logic                    apply_bkt_o,
  input  logic [1:0]              chain_flag_i,
  input  logic [WIDTH_BIN_ID-1:0] chain_bkt_bin_i,
  input  logic [WIDTH_LVL-1:0]    chain_bkt_lvl_i,
  output logic                    busy_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    unsat_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic                    err_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  bkt_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [WIDTH_LVL-1:0]    max_lvl_r_q;
  logic [WIDTH_LVL-1:0]    max_lvl_o_q;
  logic                    apply_q;
  logic                    busy_q;
  logic                    valid_q;
  logic                    unsat_q;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_q;
  logic [WIDTH_LVL-1:0]    bkt_lvl_q;
  logic                    err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      max_lvl_r_q <= '0;
      max_lvl_o_q <= '0;
      apply_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      unsat_q     <= 1'b0;
      bkt_bin_q   <= '0;
      bkt_lvl_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      apply_q <= 1'b0;
      // Abort wins over every transition, including capture and handshake.
      if (abort_i && state_q != ST_IDLE) begin
        state_q     <= ST_IDLE;
        max_lvl_o_q <= '0;
        busy_q      <= 1'b0;
        valid_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              max_lvl_r_q <= max_lvl_i;
              max_lvl_o_q <= max_lvl_i;
              cnt_q       <= CNT_LOAD;
              busy_q      <= 1'b1;
              state_q     <= ST_SEARCH;
            end
          end
          ST_SEARCH: begin
            if (cnt_q == '0) state_q <= ST_CAPTURE;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          ST_CAPTURE: begin
            bkt_bin_q <= chain_bkt_bin_i;
            bkt_lvl_q <= chain_bkt_lvl_i;
            if (chain_bkt_lvl_i > max_lvl_r_q) err_q <= 1'b1;
            if (chain_flag_i == FLAG_NONE) begin
              unsat_q     <= 1'b1;
              valid_q     <= 1'b1;
              max_lvl_o_q <= '0;
              state_q     <= ST_DONE;
            end else begin
              unsat_q <= 1'b0;
              apply_q <= 1'b1;
              state_q <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            valid_q     <= 1'b1;
            max_lvl_o_q <= '0;
            state_q     <= ST_DONE;
          end
          ST_DONE: begin
            if (ready_i) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            max_lvl_o_q <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign max_lvl_o   = max_lvl_o_q;
  assign apply_bkt_o = apply_q;
  assign busy_o      = busy_q;
  assign valid_o     = valid_q;
  assign unsat_o     = unsat_q;
  assign bkt_bin_o   = bkt_bin_q;
  assign bkt_lvl_o   = bkt_lvl_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bkt_lvl_finder.sv
// tb/tb_bkt_lvl_finder.sv - directed self-checking bench for bkt_lvl_finder
// Stubbed chain vectors from a table, plus a 4-cell chain model for apply behaviour.
module tb_bkt_lvl_finder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] max_lvl_i = '0;
  logic        abort_i = 1'b0;
  logic [15:0] max_lvl_o;
  logic        apply_bkt_o;
  logic [1:0]  chain_flag_i;
  logic [9:0]  chain_bkt_bin_i;
  logic [15:0] chain_bkt_lvl_i;
  logic        busy_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        unsat_o;
  logic [9:0]  bkt_bin_o;
  logic [15:0] bkt_lvl_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  logic        use_model = 1'b0;
  logic [1:0]  stub_flag = '0;
  logic [9:0]  stub_bin  = '0;
  logic [15:0] stub_lvl  = '0;

  logic [4:1]  has_bkt;
  logic [4:1]  preset = '0;
  logic        preset_en = 1'b0;
  logic [1:0]  mdl_flag_q = '0;
  logic [9:0]  mdl_bin_q = '0;
  logic [15:0] mdl_lvl_q = '0;

  assign chain_flag_i    = use_model ? mdl_flag_q : stub_flag;
  assign chain_bkt_bin_i = use_model ? mdl_bin_q  : stub_bin;
  assign chain_bkt_lvl_i = use_model ? mdl_lvl_q  : stub_lvl;

  bkt_lvl_finder #(.WIDTH_LVL(16), .WIDTH_BIN_ID(10), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .max_lvl_i(max_lvl_i), .abort_i(abort_i),
    .max_lvl_o(max_lvl_o), .apply_bkt_o(apply_bkt_o), .chain_flag_i(chain_flag_i),
    .chain_bkt_bin_i(chain_bkt_bin_i), .chain_bkt_lvl_i(chain_bkt_lvl_i), .busy_o(busy_o),
    .valid_o(valid_o), .ready_i(ready_i), .unsat_o(unsat_o), .bkt_bin_o(bkt_bin_o),
    .bkt_lvl_o(bkt_lvl_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Cells at levels 1..4, bin id 0x100+level; outputs registered one cycle after max_lvl_o.
  always @(posedge clk) begin
    int found;
    found = 0;
    for (int l = 4; l >= 1; l--)
      if (found == 0 && l <= int'(max_lvl_o) && !has_bkt[l]) found = l;
    if (preset_en) has_bkt <= preset;
    else if (apply_bkt_o)
      for (int l = 1; l <= 4; l++) begin
        if (l == int'(mdl_lvl_q)) has_bkt[l] <= 1'b1;
        else if (l > int'(mdl_lvl_q)) has_bkt[l] <= 1'b0;
      end
    mdl_flag_q <= (found != 0) ? 2'd1 : 2'd0;
    mdl_lvl_q  <= 16'(found);
    mdl_bin_q  <= (found != 0) ? 10'(10'h100 + found) : 10'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] mx, output int lat, output int applies,
                        output logic [15:0] srch_lvl);
    @(posedge clk); #1;
    start_i = 1'b1; max_lvl_i = mx;
    @(posedge clk); #1;
    start_i = 1'b0; lat = 1; applies = 0; srch_lvl = max_lvl_o;
    while (!valid_o && lat < 20) begin
      if (apply_bkt_o) applies++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] max_lvl;
    logic [1:0]  flag;
    logic [9:0]  bin;
    logic [15:0] lvl;
    logic        exp_unsat;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  int lat, applies, n;
  logic [15:0] srch_lvl;
  logic [9:0]  hold_bin;
  logic [15:0] hold_lvl;

  initial begin
    vecs[0] = '{16'd5,      2'd1, 10'h02A, 16'd3,      1'b0, 7, 1'b0};
    vecs[1] = '{16'd0,      2'd1, 10'h3FF, 16'd0,      1'b0, 7, 1'b0};
    vecs[2] = '{16'd8,      2'd2, 10'h001, 16'd8,      1'b0, 7, 1'b0};
    vecs[3] = '{16'd9,      2'd0, 10'h000, 16'd0,      1'b1, 6, 1'b0};
    vecs[4] = '{16'hFFFF,   2'd3, 10'h155, 16'hFFFF,   1'b0, 7, 1'b0};
    vecs[5] = '{16'd5,      2'd1, 10'h012, 16'd7,      1'b0, 7, 1'b1};

    #2;
    chk("rst_max_lvl", 32'(max_lvl_o), 0);
    chk("rst_apply", 32'(apply_bkt_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_results", {unsat_o, err_o, bkt_bin_o, bkt_lvl_o}, 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      stub_flag = vecs[i].flag; stub_bin = vecs[i].bin; stub_lvl = vecs[i].lvl;
      run_op(vecs[i].max_lvl, lat, applies, srch_lvl);
      chk($sformatf("v%0d_search_lvl", i), 32'(srch_lvl), 32'(vecs[i].max_lvl));
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_applies", i), applies, vecs[i].exp_unsat ? 0 : 1);
      chk($sformatf("v%0d_unsat", i), 32'(unsat_o), 32'(vecs[i].exp_unsat));
      chk($sformatf("v%0d_bkt_lvl", i), 32'(bkt_lvl_o), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_bkt_bin", i), 32'(bkt_bin_o), 32'(vecs[i].bin));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_done_lvl", i), 32'(max_lvl_o), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_xfer", i), {valid_o, busy_o}, 0);
    end

    // Reset pulse clears sticky err and all outputs, even mid-APPLY.
    stub_flag = 2'd1; stub_bin = 10'h0AA; stub_lvl = 16'd2;
    @(posedge clk); #1; start_i = 1'b1; max_lvl_i = 16'd4;
    @(posedge clk); #1; start_i = 1'b0;
    n = 0;
    while (!apply_bkt_o && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst_mid_in_apply", 32'(apply_bkt_o), 1);
    rst = 1'b1; #1;
    chk("rst_mid_apply", 32'(apply_bkt_o), 0);
    chk("rst_mid_outs", {busy_o, valid_o, unsat_o, err_o, max_lvl_o, bkt_bin_o, bkt_lvl_o}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Chain model: has_bkt = {l4,l3,l2,l1} = 1100, deepest free level is 2.
    use_model = 1'b1;
    preset = 4'b1100; preset_en = 1'b1;
    @(posedge clk); #1; preset_en = 1'b0;
    run_op(16'd4, lat, applies, srch_lvl);
    chk("mdl_latency", lat, 7);
    chk("mdl_applies", applies, 1);
    chk("mdl_bkt_lvl", 32'(bkt_lvl_o), 2);
    chk("mdl_bkt_bin", 32'(bkt_bin_o), 32'h102);
    chk("mdl_unsat", 32'(unsat_o), 0);
    chk("mdl_has_bkt", 32'(has_bkt), 32'b0010);
    @(posedge clk); #1;

    preset = 4'b1111; preset_en = 1'b1;
    @(posedge clk); #1; preset_en = 1'b0;
    run_op(16'd3, lat, applies, srch_lvl);
    chk("unsat_latency", lat, 6);
    chk("unsat_applies", applies, 0);
    chk("unsat_flag", 32'(unsat_o), 1);
    chk("unsat_has_bkt", 32'(has_bkt), 32'b1111);
    @(posedge clk); #1;
    use_model = 1'b0;

    // Backpressure: results hold while ready_i is low; start_i during DONE is dropped.
    stub_flag = 2'd1; stub_bin = 10'h077; stub_lvl = 16'd6;
    ready_i = 1'b0;
    run_op(16'd6, lat, applies, srch_lvl);
    chk("bp_latency", lat, 7);
    hold_bin = bkt_bin_o; hold_lvl = bkt_lvl_o;
    chk("bp_bin", 32'(hold_bin), 32'h077);
    for (int k = 0; k < 5; k++) begin
      start_i = (k == 2);
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), {valid_o, bkt_bin_o, bkt_lvl_o}, {1'b1, hold_bin, hold_lvl});
    end
    start_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_xfer", {valid_o, busy_o}, 0);
    @(posedge clk); #1;
    chk("bp_no_queue", 32'(busy_o), 0);

    // Abort in the second SEARCH cycle.
    @(posedge clk); #1; start_i = 1'b1; max_lvl_i = 16'd3;
    @(posedge clk); #1; start_i = 1'b0;
    chk("ab_search_lvl", 32'(max_lvl_o), 3);
    @(posedge clk); #1; abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    chk("ab_idle", {busy_o, max_lvl_o}, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (apply_bkt_o || valid_o || busy_o) n++;
      @(posedge clk); #1;
    end
    chk("ab_quiet", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
